// File: rtl/derate_multi_if.sv
// ============================================================================
//  Module  : derate_multi_if
//  Brief   : Control and status bundle of the multi-channel rate generator.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface derate_multi_if #(
  parameter int NCH = 2,
  parameter int W   = 27
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]  en;
  logic            sync;
  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [W-1:0]    wr_div;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  div_pending;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  tick, clk_out, div_pending
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output tick, clk_out, div_pending
  );
endinterface

`default_nettype wire

// File: rtl/derate_multi.sv
// ============================================================================
//  Module  : derate_multi
//  Brief   : NCH independent tick / square-wave generators with runtime
//            divisor hand-over at period boundaries and a common sync.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module derate_multi #(
  parameter int               NCH      = 2,
  parameter int               W        = 27,
  parameter logic [NCH*W-1:0] DIV_INIT = {27'd1_000_000, 27'd100_000_000}
) (
  input  wire logic      CLK100MHZ,
  input  wire logic      rst_n,
  derate_multi_if.slave  bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [W-1:0] C_DIV_RST = DIV_INIT[i*W +: W];

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_div;
    logic [W-1:0] r_pdiv;
    logic         r_pend;
    logic         r_tick;
    logic         r_clk;

    logic         w_wr;
    logic         w_live;
    logic         w_wrap;
    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_lo_len;

    assign w_wr      = bus.wr_en && (bus.wr_ch == CH_W'(i));
    assign w_live    = bus.en[i] && (r_div >= W'(2));
    assign w_wrap    = (r_cnt == r_div - W'(1));
    assign w_cnt_nxt = w_wrap ? '0 : r_cnt + W'(1);
    // Low phase is ceil(D/2) cycles, so the high phase is floor(D/2).
    assign w_lo_len  = r_div - (r_div >> 1);

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_div  <= C_DIV_RST;
        r_pdiv <= C_DIV_RST;
        r_pend <= 1'b0;
        r_tick <= 1'b0;
        r_clk  <= 1'b0;
      end else if (bus.sync) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_clk  <= 1'b0;
        r_pend <= 1'b0;
        if (w_wr) begin
          r_div  <= bus.wr_div;
          r_pdiv <= bus.wr_div;
        end else if (r_pend) begin
          r_div  <= r_pdiv;
        end
      end else begin
        r_tick <= w_live && w_wrap;
        if (w_live) begin
          r_clk <= (w_cnt_nxt >= w_lo_len);
          if (w_wrap && r_pend) begin
            r_div  <= r_pdiv;
            r_cnt  <= '0;
            r_pend <= 1'b0;
          end else begin
            r_cnt  <= w_cnt_nxt;
          end
        end else if (r_pend) begin
          // Idle channel: nothing to finish, so adopt the new divisor now.
          r_div  <= r_pdiv;
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_pend <= 1'b0;
        end else if (r_div < W'(2)) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
        end
        // A write in the hand-over cycle re-arms pend for the next boundary.
        if (w_wr) begin
          r_pdiv <= bus.wr_div;
          r_pend <= 1'b1;
        end
      end
    end

    assign bus.tick[i]        = r_tick;
    assign bus.clk_out[i]     = r_clk;
    assign bus.div_pending[i] = r_pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_derate_multi.sv
// ============================================================================
//  Module  : tb_derate_multi
//  Brief   : Directed plus random stimulus against a behavioural channel model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_derate_multi;
  localparam int NCH = 2;
  localparam int W   = 27;

  logic clk;
  logic rst_n;

  derate_multi_if #(.NCH(NCH), .W(W)) bus ();

  derate_multi #(
    .NCH      (NCH),
    .W        (W),
    .DIV_INIT ({27'd10, 27'd4})
  ) dut (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: position inside the current period, active and pending period
  int m_pos  [NCH];
  int m_d    [NCH];
  int m_p    [NCH];
  bit m_pend [NCH];
  bit m_tick [NCH];
  bit m_clk  [NCH];

  function automatic int init_div(input int c);
    return (c == 0) ? 4 : 10;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pos[c] = 0; m_d[c] = init_div(c); m_p[c] = init_div(c);
      m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit wr;
      int div_in;
      wr     = bus.wr_en && (int'(bus.wr_ch) == c);
      div_in = int'(bus.wr_div);
      if (bus.sync) begin
        m_pos[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
        if (wr) begin
          m_d[c] = div_in; m_p[c] = div_in;
        end else if (m_pend[c]) begin
          m_d[c] = m_p[c];
        end
        m_pend[c] = 0;
      end else begin
        m_tick[c] = 0;
        if (bus.en[c] && m_d[c] >= 2) begin
          int dold;
          dold = m_d[c];
          if (m_pos[c] + 1 == dold) begin
            m_tick[c] = 1;
            m_pos[c]  = 0;
            if (m_pend[c]) begin
              m_d[c] = m_p[c]; m_pend[c] = 0;
            end
          end else begin
            m_pos[c] = m_pos[c] + 1;
          end
          // High for the last floor(D/2) positions of the period.
          m_clk[c] = (m_pos[c] >= (dold + 1) / 2);
        end else if (m_pend[c]) begin
          m_d[c] = m_p[c]; m_pos[c] = 0; m_clk[c] = 0; m_pend[c] = 0;
        end else if (m_d[c] < 2) begin
          m_pos[c] = 0; m_clk[c] = 0;
        end
        if (wr) begin
          m_p[c] = div_in; m_pend[c] = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [NCH-1:0] obs,
                       input logic [NCH-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    logic [NCH-1:0] et, ec, ep;
    for (int c = 0; c < NCH; c++) begin
      et[c] = m_tick[c]; ec[c] = m_clk[c]; ep[c] = m_pend[c];
    end
    check("tick", bus.tick, et);
    check("clk_out", bus.clk_out, ec);
    check("div_pending", bus.div_pending, ep);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic write_div(input int ch, input int div);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 1'(ch);
    bus.wr_div = W'(div);
    cycle();
    bus.wr_en  = 1'b0;
  endtask

  task automatic wait_model_tick(input int ch);
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (m_tick[ch]) break;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.en     = '0;
    bus.sync   = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_div = '0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1;
    check_all();

    // Release, both channels running at the overridden reset divisors 4 / 10
    rst_n  = 1'b1;
    bus.en = 2'b11;
    run(40);

    // Odd divisor on ch0
    write_div(0, 5);
    run(25);

    // Mid-period rewrite: 6 then 8, only 8 must survive
    write_div(0, 4);
    wait_model_tick(0);
    run(1);
    write_div(0, 6);
    write_div(0, 8);
    run(30);

    // Freeze ch0 for 7 cycles mid-period
    wait_model_tick(0);
    run(2);
    bus.en = 2'b10;
    run(7);
    bus.en = 2'b11;
    run(20);

    // Park ch1 with 0 and 1, then restart it with 3
    write_div(1, 0);
    run(15);
    write_div(1, 1);
    run(10);
    write_div(1, 3);
    run(15);

    // Sync with a same-cycle write
    run(3);
    bus.sync   = 1'b1;
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 1'b1;
    bus.wr_div = W'(7);
    cycle();
    bus.sync   = 1'b0;
    bus.wr_en  = 1'b0;
    run(30);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.en     = 2'($urandom_range(0, 3) | (($urandom_range(0, 5) != 0) ? 3 : 0));
      bus.wr_en  = ($urandom_range(0, 5) == 0);
      bus.wr_ch  = 1'($urandom_range(0, 1));
      bus.wr_div = W'($urandom_range(0, 12));
      bus.sync   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    bus.wr_en = 1'b0;
    bus.sync  = 1'b0;
    bus.en    = 2'b11;
    run(20);

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    run(25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
